// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
// Contents:
//   PC_W / INSTR_W     - fetch address and instruction widths
//   CNT_W              - width of the consumed-instruction counter
//   OPC_MSB / OPC_LSB  - opcode field position inside an instruction
//   OPC_HALT           - opcode that stops fetch
//   fetch_state_e      - fetch control states
package cpu_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit - program counter and fetch control in front of the
// instruction memory. The memory has a one-cycle registered read, so the
// instruction on i_mem_instr always belongs to the address presented on
// o_pc one accepted edge earlier; this block remembers that address and
// whether the slot is still on-path.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active-low
//   i_stop         downstream stall, freezes all fetch state
//   i_redirect     taken branch/jump: load i_redirect_pc, squash in-flight slot
//   i_redirect_pc  redirect target
//   i_mem_instr    registered instruction-memory output
//   o_pc           fetch address to instruction memory
//   o_mem_en       memory output-register enable (advances with this block)
//   o_instr        instruction to decode (passthrough)
//   o_instr_pc     PC of o_instr
//   o_valid        o_instr is a real on-path instruction
//   o_halted       HALT consumed, fetch stopped until a redirect
//   o_fetch_cnt    saturating count of instructions consumed by decode
module fetch_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_stop,
  input  logic                       i_redirect,
  input  logic [PC_W-1:0]            i_redirect_pc,
  input  logic [INSTR_W-1:0]         i_mem_instr,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_mem_en,
  output logic [INSTR_W-1:0]         o_instr,
  output logic [PC_W-1:0]            o_instr_pc,
  output logic                       o_valid,
  output logic                       o_halted,
  output logic [cpu_pkg::CNT_W-1:0]  o_fetch_cnt
);

  import cpu_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              infl_valid_q, infl_valid_d;
  logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic consume;
  logic is_halt;

  // The memory register only moves when this block moves, so the pairing
  // of i_mem_instr with infl_pc_q survives any stall.
  assign o_mem_en = ~i_stop;

  assign consume = infl_valid_q & ~i_stop & ~i_redirect;
  assign is_halt = (i_mem_instr[OPC_MSB:OPC_LSB] == OPC_HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    infl_valid_d = infl_valid_q;
    infl_pc_d    = infl_pc_q;
    cnt_d        = cnt_q;

    if (i_redirect) begin
      // Redirect beats stall and halt; the slot already in memory is off-path.
      pc_d         = i_redirect_pc;
      infl_valid_d = 1'b0;
      state_d      = RUN;
    end else if (!i_stop) begin
      if (state_q == RUN) begin
        if (infl_valid_q && is_halt) begin
          // pc_q stays put; memory keeps re-reading it harmlessly.
          state_d      = HALTED;
          infl_valid_d = 1'b0;
        end else begin
          infl_valid_d = 1'b1;
          infl_pc_d    = pc_q;
          pc_d         = pc_q + 1'b1;
        end
      end
    end

    if (consume) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_instr     = i_mem_instr;
  assign o_instr_pc  = infl_pc_q;
  assign o_valid     = infl_valid_q;
  assign o_halted    = (state_q == HALTED);
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the documented
// scenarios, an asynchronous-reset sequence, and a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_stop;
  logic        i_redirect;
  logic [11:0] i_redirect_pc;
  logic [15:0] i_mem_instr;
  logic [11:0] o_pc;
  logic        o_mem_en;
  logic [15:0] o_instr;
  logic [11:0] o_instr_pc;
  logic        o_valid;
  logic        o_halted;
  logic [15:0] o_fetch_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:4095];

  fetch_unit dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stop        (i_stop),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_mem_instr   (i_mem_instr),
    .o_pc          (o_pc),
    .o_mem_en      (o_mem_en),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Instruction memory with a registered read port.
  always @(posedge i_clk) begin
    if (o_mem_en) i_mem_instr <= mem[o_pc];
  end

  typedef struct {
    logic        stop;
    logic        redir;
    logic [11:0] rpc;
    logic [11:0] e_pc;
    logic        e_valid;
    logic [11:0] e_ipc;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic [11:0] rpc,
                     input logic [11:0] ep, input logic ev, input logic [11:0] eipc,
                     input logic eh, input logic [15:0] ec);
    vec_t v;
    v.stop = s; v.redir = r; v.rpc = rpc;
    v.e_pc = ep; v.e_valid = ev; v.e_ipc = eipc; v.e_halted = eh; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"},     32'(o_pc),        32'h000);
    chk({tag, " valid"},  32'(o_valid),     32'h0);
    chk({tag, " ipc"},    32'(o_instr_pc),  32'h000);
    chk({tag, " halted"}, 32'(o_halted),    32'h0);
    chk({tag, " cnt"},    32'(o_fetch_cnt), 32'h0);
  endtask

  // Randomized-run reference: next address to fetch, the address whose
  // instruction decode currently sees, and the halt/count bookkeeping.
  int m_next, m_vis_pc, m_cnt;
  bit m_vis_valid, m_halted;

  initial begin
    i_reset = 1'b0;
    i_stop = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;

    for (int a = 0; a < 4096; a++) mem[a] = 16'((((a % 14) + 1) << 12) | (a & 12'hFFF));
    mem[0] = 16'h1438; mem[1] = 16'h282F; mem[2] = 16'h1121; mem[3] = 16'h1242;
    mem[4] = 16'hF000;
    mem[12'h200] = 16'hF123;

    // stop redir rpc | pc valid ipc halted cnt
    add(0, 0, 12'h000, 12'h001, 1, 12'h000, 0, 0);
    add(0, 0, 12'h000, 12'h002, 1, 12'h001, 0, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 12'h000, 12'h002, 1, 12'h001, 0, 1);
    add(0, 0, 12'h000, 12'h003, 1, 12'h002, 0, 2);
    add(0, 0, 12'h000, 12'h004, 1, 12'h003, 0, 3);
    add(0, 0, 12'h000, 12'h005, 1, 12'h004, 0, 4);
    add(0, 0, 12'h000, 12'h005, 0, 12'h000, 1, 5);
    for (int k = 0; k < 10; k++) add(0, 0, 12'h000, 12'h005, 0, 12'h000, 1, 5);
    add(0, 1, 12'h000, 12'h000, 0, 12'h000, 0, 5);
    add(0, 0, 12'h000, 12'h001, 1, 12'h000, 0, 5);
    add(0, 0, 12'h000, 12'h002, 1, 12'h001, 0, 6);
    add(0, 0, 12'h000, 12'h003, 1, 12'h002, 0, 7);
    add(0, 1, 12'h100, 12'h100, 0, 12'h000, 0, 7);
    add(0, 0, 12'h000, 12'h101, 1, 12'h100, 0, 7);
    add(0, 0, 12'h000, 12'h102, 1, 12'h101, 0, 8);
    add(1, 1, 12'hFFE, 12'hFFE, 0, 12'h000, 0, 8);
    add(1, 0, 12'h000, 12'hFFE, 0, 12'h000, 0, 8);
    add(0, 0, 12'h000, 12'hFFF, 1, 12'hFFE, 0, 8);
    add(0, 0, 12'h000, 12'h000, 1, 12'hFFF, 0, 9);
    add(0, 0, 12'h000, 12'h001, 1, 12'h000, 0, 10);
    add(0, 0, 12'h000, 12'h002, 1, 12'h001, 0, 11);
    add(0, 0, 12'h000, 12'h003, 1, 12'h002, 0, 12);
    add(0, 1, 12'h200, 12'h200, 0, 12'h000, 0, 12);
    add(0, 0, 12'h000, 12'h201, 1, 12'h200, 0, 12);
    add(0, 1, 12'h050, 12'h050, 0, 12'h000, 0, 12);
    add(0, 0, 12'h000, 12'h051, 1, 12'h050, 0, 12);

    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_vals("reset");

    @(negedge i_clk);
    i_reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      i_stop        = vecs[i].stop;
      i_redirect    = vecs[i].redir;
      i_redirect_pc = vecs[i].rpc;
      @(posedge i_clk);
      #1;
      chk($sformatf("row%0d pc", i),     32'(o_pc),        32'(vecs[i].e_pc));
      chk($sformatf("row%0d valid", i),  32'(o_valid),     32'(vecs[i].e_valid));
      chk($sformatf("row%0d halted", i), 32'(o_halted),    32'(vecs[i].e_halted));
      chk($sformatf("row%0d cnt", i),    32'(o_fetch_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d ipc", i),   32'(o_instr_pc), 32'(vecs[i].e_ipc));
        chk($sformatf("row%0d instr", i), 32'(o_instr),    32'(mem[vecs[i].e_ipc]));
      end
      @(negedge i_clk);
    end
    i_stop = 1'b0;
    i_redirect = 1'b0;

    // Asynchronous reset away from any clock edge.
    #1 i_reset = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk("restart pc",    32'(o_pc),       32'h001);
    chk("restart valid", 32'(o_valid),    32'h1);
    chk("restart ipc",   32'(o_instr_pc), 32'h000);
    chk("restart instr", 32'(o_instr),    32'(mem[0]));

    // Randomized run with fresh memory contents.
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    @(negedge i_clk);
    i_reset = 1'b1;
    m_next = 0; m_vis_pc = 0; m_vis_valid = 0; m_halted = 0; m_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      bit consume;
      i_stop        = ($urandom_range(0, 3) == 0);
      i_redirect    = ($urandom_range(0, 7) == 0);
      i_redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFD : 12'($urandom);
      @(posedge i_clk);
      consume = m_vis_valid && !i_stop && !i_redirect;
      if (consume && m_cnt < 65535) m_cnt++;
      if (i_redirect) begin
        m_next = int'(i_redirect_pc);
        m_vis_valid = 0;
        m_halted = 0;
      end else if (!i_stop && !m_halted) begin
        if (m_vis_valid && mem[m_vis_pc][15:12] == 4'hF) begin
          m_halted = 1;
          m_vis_valid = 0;
        end else begin
          m_vis_pc = m_next;
          m_vis_valid = 1;
          m_next = (m_next + 1) % 4096;
        end
      end
      #1;
      chk($sformatf("rnd%0d pc", c),     32'(o_pc),        32'(m_next));
      chk($sformatf("rnd%0d valid", c),  32'(o_valid),     32'(m_vis_valid));
      chk($sformatf("rnd%0d halted", c), 32'(o_halted),    32'(m_halted));
      chk($sformatf("rnd%0d cnt", c),    32'(o_fetch_cnt), 32'(m_cnt));
      if (m_vis_valid) begin
        chk($sformatf("rnd%0d ipc", c),   32'(o_instr_pc), 32'(m_vis_pc));
        chk($sformatf("rnd%0d instr", c), 32'(o_instr),    32'(mem[m_vis_pc]));
      end
      @(negedge i_clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage directly upstream of the instruction memory in the 16-bit CPU. Generates the 12-bit fetch address, tracks the one-cycle registered memory latency, and pairs each returned instruction with its PC and a valid bit for decode. Handles downstream stall, branch/jump redirect with squash of the in-flight fetch, PC wrap-around, and halt on the HALT opcode.

## Interface
- PC_W, 12, fetch address width
- INSTR_W, 16, instruction width
- RESET_PC, 12'h000, first fetch address after reset
- i_clk  input  1  clock, rising edge
- i_reset  input  1  reset, asynchronous, active-low
- i_stop  input  1  downstream stall; hold all fetch state
- i_redirect  input  1  branch/jump taken; load new PC, squash in-flight fetch
- i_redirect_pc  input  12  redirect target
- i_mem_instr  input  16  registered instruction-memory output (mem[address] one cycle after the address is accepted)
- o_pc  output  12  address to instruction memory
- o_mem_en  output  1  memory output-register update enable
- o_instr  output  16  instruction to decode (passthrough of i_mem_instr)
- o_instr_pc  output  12  PC of o_instr
- o_valid  output  1  o_instr is a real, on-path instruction
- o_halted  output  1  HALT consumed; fetch stopped
- o_fetch_cnt  output  16  count of instructions consumed by decode, saturating

## Operation
- Reset values: o_pc=RESET_PC, o_valid=0, o_instr_pc=0, o_halted=0, o_fetch_cnt=0; state RUN.
- States: RUN, HALTED.
- Registers: pc_q (drives o_pc), infl_valid (o_valid), infl_pc (o_instr_pc).
- o_mem_en = ~i_stop (combinational); memory and this block advance together.
- Consume event = o_valid & ~i_stop & ~i_redirect.
- Priority per cycle: redirect > stop > halt > normal advance.
- Redirect (either state, stop ignored): pc_q<=i_redirect_pc; infl_valid<=0; state<=RUN; o_halted<=0.
- Stop, no redirect: all registers hold; counter holds.
- RUN, consume of instruction with o_instr[15:12]==4'hF (HALT): state<=HALTED, o_halted<=1, infl_valid<=0, pc_q holds.
- RUN, normal: infl_valid<=1; infl_pc<=pc_q; pc_q<=pc_q+1, modulo 2^12 (12'hFFF wraps to 12'h000, no flag).
- HALTED, no redirect: pc_q, infl_valid=0 held; memory keeps fetching the held address harmlessly.
- o_fetch_cnt increments by 1 on each consume event; saturates at 16'hFFFF; cleared only by reset.
- Only i_mem_instr[15:12] is inspected; all other fields pass through unchanged.

## Timing
- Fetch latency: address on o_pc at edge N accepted -> instruction on o_instr with o_valid=1 after edge N+1.
- First valid instruction: reset release, then first unstalled edge loads mem[RESET_PC]; o_valid=1, o_instr_pc=RESET_PC after that edge.
- Steady state: one instruction per cycle, o_instr_pc increments by 1 each unstalled cycle.
- Redirect at edge N: o_valid=0 for cycle after N (bubble); target instruction valid after N+1 if unstalled. Redirect penalty: exactly one bubble.
- Redirect with simultaneous HALT on o_instr: redirect wins, no halt.
- Redirect with simultaneous i_stop: redirect taken; subsequent stall holds the new pc_q.
- Async reset mid-operation: all registers to reset values immediately; in-flight instruction discarded.

## Structure
- Shared cpu_pkg: PC_W, INSTR_W, OPC_MSB/OPC_LSB (15/12), OPC_HALT=4'hF, fetch state enum {RUN, HALTED}.
- Single module; no natural sub-module. Instruction memory stays a separate block, connected via o_pc/o_mem_en/i_mem_instr.

## Test plan
- Reset, memory preloaded mem[0..3]=16'h1438,16'h282F,16'h1121,16'h1242, no stop -> o_valid rises one edge after release; o_instr_pc 0,1,2,3 with matching o_instr; o_fetch_cnt=4 after four consumes.
- i_stop high 3 cycles while o_instr_pc=1 -> o_pc, o_instr, o_instr_pc, o_valid, o_fetch_cnt frozen; resume with pc 2 next, no duplicate or skip.
- i_redirect with target 12'h100 while o_instr_pc=2 -> one cycle o_valid=0, then o_instr_pc=12'h100, 12'h101; instruction at pc 3 never valid; counter excludes squashed slot.
- mem[4]=16'hF000 -> after consume o_halted=1, o_valid=0, o_pc steady 5 for 10 cycles; then redirect to 0 -> o_halted=0, fetch resumes at 0.
- Redirect to 12'hFFE -> o_instr_pc FFE, FFF, 000, 001 consecutively.
- Assert i_reset low with o_instr_pc=12'h050, o_halted=0, o_fetch_cnt=12 -> outputs to reset values asynchronously; after release fetch restarts at RESET_PC.
